// File: rtl/btn_conditioner.sv
// Push-button front end for the lock FSM: two-flop synchroniser, per-channel debounce,
// and one-tick-wide press pulses with a sticky lost-press flag.
module btn_conditioner #(
  parameter int unsigned N_BTN     = 3,
  parameter int unsigned DB_CYCLES = 1000000,
  parameter int unsigned CNT_W     = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic             lost_clr,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_pulse,
  output logic [N_BTN-1:0] press_lost
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  // Marks the first cycle whose synchronised sample reflects the pins after reset.
  logic [2:0] r_vld;
  logic       w_first_vld;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_vld <= '0;
    else      r_vld <= {r_vld[1:0], 1'b1};
  end

  assign w_first_vld = r_vld[1] & ~r_vld[2];

  for (genvar g = 0; g < int'(N_BTN); g++) begin : g_ch
    logic             r_meta;
    logic             r_sync;
    logic             r_stable;
    logic             r_prev;
    logic             r_armed;
    logic             r_pending;
    logic             r_pulse;
    logic             r_lost;
    logic [CNT_W-1:0] r_cnt;
    logic             w_rise;
    logic             w_fall;

    // A button already held through reset stays unarmed until a debounced release.
    assign w_rise = r_stable & ~r_prev & r_armed;
    assign w_fall = ~r_stable & r_prev;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_meta   <= 1'b0;
        r_sync   <= 1'b0;
        r_stable <= 1'b0;
        r_prev   <= 1'b0;
        r_armed  <= 1'b0;
        r_cnt    <= '0;
      end else begin
        r_meta <= btn_raw[g];
        r_sync <= r_meta;
        r_prev <= r_stable;
        if (r_sync == r_stable) begin
          r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
          r_stable <= r_sync;
          r_cnt    <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
        if (w_fall || (w_first_vld && !r_sync)) r_armed <= 1'b1;
      end
    end

    // One-deep press queue drained on each tick; a second press while queued is lost.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_pending <= 1'b0;
        r_pulse   <= 1'b0;
        r_lost    <= 1'b0;
      end else begin
        if (tick) begin
          r_pulse   <= r_pending;
          r_pending <= w_rise;
        end else if (w_rise) begin
          r_pending <= 1'b1;
        end
        if (!tick && w_rise && r_pending) r_lost <= 1'b1;
        else if (lost_clr)                r_lost <= 1'b0;
      end
    end

    assign btn_level[g]  = r_stable;
    assign btn_pulse[g]  = r_pulse;
    assign press_lost[g] = r_lost;
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: directed press scenarios plus random bouncing buttons,
// every cycle compared against a sample-history reference model.
module tb_btn_conditioner;

  localparam int unsigned N  = 3;
  localparam int unsigned DB = 4;
  localparam int unsigned CW = 20;
  localparam int unsigned TP = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         tick;
  logic         lost_clr;
  logic [N-1:0] btn_raw;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_pulse;
  logic [N-1:0] press_lost;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  btn_conditioner #(.N_BTN(N), .DB_CYCLES(DB), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .btn_raw   (btn_raw),
    .lost_clr  (lost_clr),
    .btn_level (btn_level),
    .btn_pulse (btn_pulse),
    .press_lost(press_lost)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: raw history gives sync, a window of the last DB sync samples gives the
  // debounced level, and a one-deep press queue is drained on every tick.
  bit [N-1:0] m_rh0, m_rh1, m_stable, m_rose, m_fell, m_armed, m_pend, m_pulse, m_lost;
  bit [N-1:0] m_sh [DB];
  int         m_ecnt;

  task automatic model_reset();
    m_rh0 = '0; m_rh1 = '0; m_stable = '0; m_rose = '0; m_fell = '0;
    m_armed = '0; m_pend = '0; m_pulse = '0; m_lost = '0; m_ecnt = 0;
    for (int j = 0; j < int'(DB); j++) m_sh[j] = '0;
  endtask

  task automatic model_step();
    bit [N-1:0] sync, rise, set_lost, nxt;
    bit         all_diff;
    if (!rst) begin
      model_reset();
      return;
    end
    m_ecnt++;
    sync = m_rh1;
    rise = m_rose & m_armed;
    if (m_ecnt == 3) m_armed |= ~sync;
    m_armed |= m_fell;
    set_lost = '0;
    for (int c = 0; c < int'(N); c++) begin
      if (tick) begin
        m_pulse[c] = m_pend[c];
        m_pend[c]  = rise[c];
      end else if (rise[c]) begin
        if (m_pend[c]) set_lost[c] = 1'b1;
        else           m_pend[c]   = 1'b1;
      end
    end
    if (lost_clr) m_lost = '0;
    m_lost |= set_lost;
    for (int j = int'(DB) - 1; j > 0; j--) m_sh[j] = m_sh[j-1];
    m_sh[0] = sync;
    nxt = m_stable;
    for (int c = 0; c < int'(N); c++) begin
      all_diff = 1'b1;
      for (int j = 0; j < int'(DB); j++) if (m_sh[j][c] == m_stable[c]) all_diff = 1'b0;
      if (all_diff) nxt[c] = ~m_stable[c];
    end
    m_rose   = nxt & ~m_stable;
    m_fell   = m_stable & ~nxt;
    m_stable = nxt;
    m_rh1    = m_rh0;
    m_rh0    = btn_raw;
  endtask

  task automatic step(input logic [N-1:0] raw, input logic lc);
    btn_raw  = raw;
    lost_clr = lc;
    tick     = (cyc % int'(TP)) == (int'(TP) - 1);
    @(posedge clk);
    model_step();
    cyc++;
    @(negedge clk);
    check_eq("level", 32'(btn_level),  32'(m_stable));
    check_eq("pulse", 32'(btn_pulse),  32'(m_pulse));
    check_eq("lost",  32'(press_lost), 32'(m_lost));
  endtask

  task automatic hold(input logic [N-1:0] raw, input int n);
    for (int i = 0; i < n; i++) step(raw, 1'b0);
  endtask

  task automatic wait_phase(input int ph);
    while ((cyc % int'(TP)) != ph) step('0, 1'b0);
  endtask

  task automatic run_count(input logic [N-1:0] raw, input int n, input logic [N-1:0] pat,
                           output int hits, output int rises);
    bit prev, cur;
    hits  = 0;
    rises = 0;
    prev  = (btn_pulse == pat);
    for (int i = 0; i < n; i++) begin
      step(raw, 1'b0);
      cur = (btn_pulse == pat);
      if (cur) hits++;
      if (cur && !prev) rises++;
      prev = cur;
    end
  endtask

  task automatic do_reset(input logic [N-1:0] raw);
    rst = 1'b0;
    #1;
    check_eq("rst_level", 32'(btn_level),  32'd0);
    check_eq("rst_pulse", 32'(btn_pulse),  32'd0);
    check_eq("rst_lost",  32'(press_lost), 32'd0);
    model_reset();
    step(raw, 1'b0);
    step(raw, 1'b0);
    rst = 1'b1;
  endtask

  initial begin
    int         lat, hits, rises, first, width;
    bit [N-1:0] intent;
    int         bnc [N];
    logic [N-1:0] raw;

    rst = 1'b0; tick = 1'b0; lost_clr = 1'b0; btn_raw = '0;
    model_reset();
    #2;
    check_eq("init_level", 32'(btn_level),  32'd0);
    check_eq("init_pulse", 32'(btn_pulse),  32'd0);
    check_eq("init_lost",  32'(press_lost), 32'd0);
    hold('0, 3);
    rst = 1'b1;
    hold('0, 20);

    // Clean press: level latency, one 16-cycle pulse while held for 100 cycles.
    step(3'b001, 1'b0);
    lat = 1;
    while (btn_level[0] == 1'b0 && lat < 20) begin
      step(3'b001, 1'b0);
      lat++;
    end
    check_eq("clean_latency", 32'(lat), 32'd6);
    run_count(3'b001, 94, 3'b001, hits, rises);
    check_eq("clean_width", 32'(hits),  32'd16);
    check_eq("clean_count", 32'(rises), 32'd1);
    hold('0, 40);

    // Bouncing press.
    hold(3'b001, 2); hold('0, 2); hold(3'b001, 2); hold('0, 2);
    step(3'b001, 1'b0);
    lat = 1;
    while (btn_level[0] == 1'b0 && lat < 20) begin
      step(3'b001, 1'b0);
      lat++;
    end
    check_eq("bounce_latency", 32'(lat), 32'd6);
    run_count(3'b001, 60, 3'b001, hits, rises);
    check_eq("bounce_count", 32'(rises), 32'd1);
    check_eq("bounce_lost", 32'(press_lost[0]), 32'd0);
    hold('0, 40);

    // Rise lands on a tick edge: queued for the following tick.
    wait_phase(9);
    step(3'b001, 1'b0);
    first = 0;
    width = 0;
    for (int k = 1; k <= 50; k++) begin
      step(3'b001, 1'b0);
      if (btn_pulse[0] && first == 0) first = k;
      if (btn_pulse[0]) width++;
    end
    check_eq("coinc_start", 32'(first), 32'd22);
    check_eq("coinc_width", 32'(width), 32'd16);
    hold('0, 40);

    // Two presses inside one tick interval: one pulse, lost flag, then clear.
    wait_phase(10);
    hold(3'b001, 5);
    hold('0, 5);
    run_count(3'b001, 40, 3'b001, hits, rises);
    check_eq("double_count", 32'(rises), 32'd1);
    check_eq("double_lost", 32'(press_lost[0]), 32'd1);
    step(3'b001, 1'b1);
    check_eq("lost_cleared", 32'(press_lost[0]), 32'd0);
    hold('0, 40);

    // Simultaneous ent and change.
    run_count(3'b101, 60, 3'b101, hits, rises);
    check_eq("multi_width", 32'(hits),  32'd16);
    check_eq("multi_count", 32'(rises), 32'd1);
    hold('0, 40);

    // Reset while a pulse is out and another press is queued, button held through it.
    wait_phase(10);
    hold(3'b001, 22);
    hold('0, 5);
    hold(3'b001, 8);
    check_eq("pre_rst_pulse", 32'(btn_pulse[0]), 32'd1);
    do_reset(3'b001);
    run_count(3'b001, 100, 3'b001, hits, rises);
    check_eq("held_no_pulse", 32'(rises), 32'd0);
    check_eq("held_level", 32'(btn_level[0]), 32'd1);
    hold('0, 40);
    run_count(3'b001, 60, 3'b001, hits, rises);
    check_eq("repress_count", 32'(rises), 32'd1);
    hold('0, 40);

    // Random bouncing buttons on all channels, with a reset in the middle.
    intent = '0;
    for (int c = 0; c < int'(N); c++) bnc[c] = 0;
    for (int i = 0; i < 2000; i++) begin
      for (int c = 0; c < int'(N); c++) begin
        if (bnc[c] > 0) begin
          bnc[c]--;
          raw[c] = 1'($urandom_range(0, 1));
        end else begin
          if ($urandom_range(0, 39) == 0) begin
            intent[c] = ~intent[c];
            bnc[c]    = int'($urandom_range(0, 7));
          end
          raw[c] = intent[c];
        end
      end
      if (i == 1000) do_reset(raw);
      step(raw, $urandom_range(0, 49) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
